// File: rtl/reg_bus_sched.sv
// Register-bus scheduler: round-robin grant among requesters, range decode onto one of
// the register slaves, one transaction in flight, local error for misses and hung slaves.
module reg_bus_sched #(
  parameter int unsigned                 NumReq        = 2,
  parameter int unsigned                 NumSlv        = 4,
  parameter int unsigned                 AddrWidth     = 64,
  parameter int unsigned                 DataWidth     = 32,
  parameter int unsigned                 TimeoutCycles = 1024,
  parameter logic [NumSlv*AddrWidth-1:0] SlvStart      = '0,
  parameter logic [NumSlv*AddrWidth-1:0] SlvEnd        = '0
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [NumReq-1:0]               req_valid_i,
  input  logic [NumReq-1:0]               req_write_i,
  input  logic [NumReq*AddrWidth-1:0]     req_addr_i,
  input  logic [NumReq*DataWidth-1:0]     req_wdata_i,
  input  logic [NumReq*(DataWidth/8)-1:0] req_wstrb_i,
  output logic [NumReq-1:0]               req_ready_o,
  output logic [DataWidth-1:0]            req_rdata_o,
  output logic                            req_error_o,
  output logic [NumSlv-1:0]               slv_valid_o,
  output logic                            slv_write_o,
  output logic [AddrWidth-1:0]            slv_addr_o,
  output logic [DataWidth-1:0]            slv_wdata_o,
  output logic [DataWidth/8-1:0]          slv_wstrb_o,
  input  logic [NumSlv-1:0]               slv_ready_i,
  input  logic [NumSlv*DataWidth-1:0]     slv_rdata_i,
  input  logic [NumSlv-1:0]               slv_error_i,
  output logic                            busy_o,
  output logic                            timeout_o
);

  localparam int unsigned StrbWidth = DataWidth / 8;
  localparam int unsigned ReqIdxW   = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam int unsigned SlvIdxW   = (NumSlv > 1) ? $clog2(NumSlv) : 1;
  localparam int unsigned CntW      = $clog2(TimeoutCycles);

  localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCycles - 1);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StAccess = 2'd1;
  localparam logic [1:0] StResp   = 2'd2;

  logic [1:0]           r_state;
  logic [ReqIdxW-1:0]   r_ptr;
  logic [ReqIdxW-1:0]   r_grant;
  logic                 r_write;
  logic [AddrWidth-1:0] r_addr;
  logic [DataWidth-1:0] r_wdata;
  logic [StrbWidth-1:0] r_wstrb;
  logic [SlvIdxW-1:0]   r_sel;
  logic                 r_miss;
  logic [CntW-1:0]      r_cnt;
  logic [DataWidth-1:0] r_rdata;
  logic                 r_error;
  logic                 r_timeout;

  logic                 w_any_req;
  logic [ReqIdxW-1:0]   w_gnt_idx;
  logic                 w_gnt_write;
  logic [AddrWidth-1:0] w_gnt_addr;
  logic [DataWidth-1:0] w_gnt_wdata;
  logic [StrbWidth-1:0] w_gnt_wstrb;
  logic                 w_hit;
  logic [SlvIdxW-1:0]   w_hit_idx;
  logic                 w_slv_ready;
  logic [DataWidth-1:0] w_slv_rdata;
  logic                 w_slv_error;

  // Round-robin: first pass covers requesters at/after the pointer, second pass wraps.
  always_comb begin
    w_any_req = 1'b0;
    w_gnt_idx = '0;
    for (int i = 0; i < NumReq; i++) begin
      if (!w_any_req && req_valid_i[i] && (i >= int'(r_ptr))) begin
        w_any_req = 1'b1;
        w_gnt_idx = ReqIdxW'(i);
      end
    end
    for (int i = 0; i < NumReq; i++) begin
      if (!w_any_req && req_valid_i[i]) begin
        w_any_req = 1'b1;
        w_gnt_idx = ReqIdxW'(i);
      end
    end
  end

  always_comb begin
    w_gnt_write = 1'b0;
    w_gnt_addr  = '0;
    w_gnt_wdata = '0;
    w_gnt_wstrb = '0;
    for (int i = 0; i < NumReq; i++) begin
      if (w_gnt_idx == ReqIdxW'(i)) begin
        w_gnt_write = req_write_i[i];
        w_gnt_addr  = req_addr_i[i*AddrWidth +: AddrWidth];
        w_gnt_wdata = req_wdata_i[i*DataWidth +: DataWidth];
        w_gnt_wstrb = req_wstrb_i[i*StrbWidth +: StrbWidth];
      end
    end
  end

  // Lowest-index range wins on overlap; an empty range (start == end) can never match.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_idx = '0;
    for (int i = 0; i < NumSlv; i++) begin
      if (!w_hit &&
          (w_gnt_addr >= SlvStart[i*AddrWidth +: AddrWidth]) &&
          (w_gnt_addr <  SlvEnd[i*AddrWidth +: AddrWidth])) begin
        w_hit     = 1'b1;
        w_hit_idx = SlvIdxW'(i);
      end
    end
  end

  always_comb begin
    w_slv_ready = 1'b0;
    w_slv_rdata = '0;
    w_slv_error = 1'b0;
    for (int i = 0; i < NumSlv; i++) begin
      if (r_sel == SlvIdxW'(i)) begin
        w_slv_ready = slv_ready_i[i];
        w_slv_rdata = slv_rdata_i[i*DataWidth +: DataWidth];
        w_slv_error = slv_error_i[i];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= StIdle;
      r_ptr     <= '0;
      r_grant   <= '0;
      r_write   <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_sel     <= '0;
      r_miss    <= 1'b0;
      r_cnt     <= '0;
      r_rdata   <= '0;
      r_error   <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        StIdle: begin
          if (w_any_req) begin
            r_state <= StAccess;
            r_grant <= w_gnt_idx;
            r_write <= w_gnt_write;
            r_addr  <= w_gnt_addr;
            r_wdata <= w_gnt_wdata;
            r_wstrb <= w_gnt_wstrb;
            r_sel   <= w_hit_idx;
            r_miss  <= !w_hit;
            r_cnt   <= '0;
          end
        end
        StAccess: begin
          r_cnt <= r_cnt + CntW'(1);
          if (r_miss) begin
            r_rdata <= '0;
            r_error <= 1'b1;
            r_state <= StResp;
          end else if (w_slv_ready) begin
            // Ready takes priority over an abort landing in the same cycle.
            r_rdata <= w_slv_rdata;
            r_error <= w_slv_error;
            r_state <= StResp;
          end else if (r_cnt == CntLast) begin
            r_rdata   <= '0;
            r_error   <= 1'b1;
            r_timeout <= 1'b1;
            r_state   <= StResp;
          end
        end
        StResp: begin
          r_ptr   <= (32'(r_grant) == NumReq - 1) ? '0 : r_grant + 1'b1;
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  always_comb begin
    slv_valid_o = '0;
    req_ready_o = '0;
    for (int i = 0; i < NumSlv; i++) begin
      slv_valid_o[i] = (r_state == StAccess) && !r_miss && (r_sel == SlvIdxW'(i));
    end
    for (int i = 0; i < NumReq; i++) begin
      req_ready_o[i] = (r_state == StResp) && (r_grant == ReqIdxW'(i));
    end
  end

  assign req_rdata_o = (r_state == StResp) ? r_rdata : '0;
  assign req_error_o = (r_state == StResp) ? r_error : 1'b0;
  assign slv_write_o = r_write;
  assign slv_addr_o  = r_addr;
  assign slv_wdata_o = r_wdata;
  assign slv_wstrb_o = r_wstrb;
  assign busy_o      = (r_state != StIdle);
  assign timeout_o   = r_timeout;

endmodule
